// File: rtl/dcache_write_buffer_pkg.sv
// Shared types and widths for the data-cache write buffer.
package dcache_write_buffer_pkg;

    localparam int BLOCK_ADDR_W = 28;
    localparam int BLOCK_W      = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_READ,
        ST_RD_DONE
    } wb_state_e;

endpackage

// File: rtl/dcache_write_buffer_wb_fifo.sv
// Circular block store for evicted cache lines, with a newest-first address match
// used to forward buffered data back to the cache.
module wb_fifo
    import dcache_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [BLOCK_ADDR_W-1:0]     push_addr,
    input  logic [BLOCK_W-1:0]          push_data,
    input  logic                        pop,
    input  logic [BLOCK_ADDR_W-1:0]     lookup_addr,
    output logic [BLOCK_ADDR_W-1:0]     head_addr,
    output logic [BLOCK_W-1:0]          head_data,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        hit,
    output logic [BLOCK_W-1:0]          hit_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic                    valid_q [DEPTH];
    logic                    valid_d [DEPTH];
    logic [BLOCK_ADDR_W-1:0] addr_q  [DEPTH];
    logic [BLOCK_ADDR_W-1:0] addr_d  [DEPTH];
    logic [BLOCK_W-1:0]      data_q  [DEPTH];
    logic [BLOCK_W-1:0]      data_d  [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    push_ok, pop_ok;
    logic [PTR_W-1:0]        idx;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign push_ok   = push & ~full;
    assign pop_ok    = pop & (count_q != '0);
    assign count     = count_q;
    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];

    always_comb begin
        valid_d  = valid_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            valid_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q]  = push_addr;
            data_d[wr_ptr_q]  = push_data;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Walk oldest to newest so the last match (the newest block) wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (valid_q[idx] && (addr_q[idx] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '{default: '0};
            addr_q   <= '{default: '0};
            data_q   <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dcache_write_buffer.sv
// Write buffer between the data cache and memory: queues evicted blocks, drains them
// in the background, forwards buffered blocks to reads, and lets read misses jump the queue.
module dcache_write_buffer
    import dcache_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        c_read,
    input  logic                        c_write,
    input  logic [BLOCK_ADDR_W-1:0]     c_address,
    input  logic [BLOCK_W-1:0]          c_writedata,
    output logic [BLOCK_W-1:0]          c_readdata,
    output logic                        c_busywait,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [BLOCK_ADDR_W-1:0]     mem_address,
    output logic [BLOCK_W-1:0]          mem_writedata,
    input  logic [BLOCK_W-1:0]          mem_readdata,
    input  logic                        mem_busywait,
    output logic [$clog2(DEPTH):0]      wb_count
);

    wb_state_e               state_q, state_d;
    logic [BLOCK_W-1:0]      rdata_q, rdata_d;
    logic                    push, pop, full, hit;
    logic [BLOCK_ADDR_W-1:0] head_addr;
    logic [BLOCK_W-1:0]      head_data, hit_data;

    // A simultaneous read and write is a protocol error; the read takes precedence.
    assign push = c_write & ~c_read;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clock),
        .rst        (reset),
        .push       (push),
        .push_addr  (c_address),
        .push_data  (c_writedata),
        .pop        (pop),
        .lookup_addr(c_address),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (wb_count),
        .full       (full),
        .hit        (hit),
        .hit_data   (hit_data)
    );

    always_comb begin
        if (c_read) begin
            c_busywait = ~hit & (state_q != ST_RD_DONE);
        end else begin
            c_busywait = c_write & full;
        end

        if (state_q == ST_RD_DONE) begin
            c_readdata = rdata_q;
        end else if (c_read && hit) begin
            c_readdata = hit_data;
        end else begin
            c_readdata = '0;
        end
    end

    always_comb begin
        state_d       = state_q;
        rdata_d       = rdata_q;
        pop           = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        case (state_q)
            ST_IDLE: begin
                if (c_read && !hit) begin
                    state_d = ST_READ;
                end else if (wb_count != '0) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                mem_write     = 1'b1;
                mem_address   = head_addr;
                mem_writedata = head_data;
                if (!mem_busywait) begin
                    pop     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                mem_read    = 1'b1;
                mem_address = c_address;
                if (!mem_busywait) begin
                    rdata_d = mem_readdata;
                    state_d = ST_RD_DONE;
                end
            end
            ST_RD_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed self-checking bench for dcache_write_buffer with a latency-programmable memory model.
module tb_dcache_write_buffer;

    logic         clock = 1'b0;
    logic         reset;
    logic         c_read, c_write;
    logic [27:0]  c_address;
    logic [127:0] c_writedata, c_readdata;
    logic         c_busywait;
    logic         mem_read, mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata, mem_readdata;
    logic         mem_busywait;
    logic [2:0]   wb_count;

    int n_checks = 0;
    int n_fail   = 0;

    int lat   = 1;
    int mcnt  = 0;
    int wcnt  = 0;
    int rdcnt = 0;
    logic [27:0]  wlog_addr [0:63];
    logic [127:0] wlog_data [0:63];

    dcache_write_buffer #(.DEPTH(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .c_read       (c_read),
        .c_write      (c_write),
        .c_address    (c_address),
        .c_writedata  (c_writedata),
        .c_readdata   (c_readdata),
        .c_busywait   (c_busywait),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait),
        .wb_count     (wb_count)
    );

    always #5 clock = ~clock;

    // Memory: an operation finishes in its lat-th cycle.
    assign mem_busywait = (mem_read || mem_write) && (mcnt != lat - 1);

    always @(posedge clock) begin
        if (mem_read || mem_write) begin
            if (!mem_busywait) begin
                mcnt <= 0;
                if (mem_write) begin
                    wlog_addr[wcnt] <= mem_address;
                    wlog_data[wcnt] <= mem_writedata;
                    wcnt <= wcnt + 1;
                end else begin
                    rdcnt <= rdcnt + 1;
                end
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    function automatic logic [127:0] blk(input logic [27:0] a);
        return {4{32'hC0DE_0000 | {4'h0, a}}};
    endfunction

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        c_read  = 1'b0;
        c_write = 1'b0;
        for (int k = 0; k < 3; k++) step();
    endtask

    task automatic test_reset;
        reset = 1'b1; c_read = 1'b0; c_write = 1'b0;
        c_address = '0; c_writedata = '0; mem_readdata = '0;
        #2;
        n_checks++; if (wb_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", wb_count); end
        n_checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem got rd=%b wr=%b exp 0 0", mem_read, mem_write); end
        n_checks++; if (c_busywait !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", c_busywait); end
        n_checks++; if (c_readdata !== 128'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", c_readdata); end
        c_read = 1'b1;
        #1;
        n_checks++; if (c_busywait !== 1'b1) begin n_fail++; $display("FAIL reset_busy_read got %b exp 1", c_busywait); end
        c_read = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_write;
        int w0;
        w0 = wcnt; lat = 3;
        c_write = 1'b1; c_address = 28'h0000010;
        c_writedata = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        #1;
        n_checks++; if (c_busywait !== 1'b0) begin n_fail++; $display("FAIL single_stall got %b exp 0", c_busywait); end
        step();
        c_write = 1'b0;
        #1;
        n_checks++; if (wb_count !== 3'd1) begin n_fail++; $display("FAIL single_count1 got %0d exp 1", wb_count); end
        for (int k = 0; k < 20 && wcnt != w0 + 1; k++) step();
        n_checks++; if (wcnt !== w0 + 1) begin n_fail++; $display("FAIL single_drain got %0d writes exp %0d", wcnt - w0, 1); end
        n_checks++; if (wlog_addr[w0] !== 28'h0000010) begin n_fail++; $display("FAIL single_addr got %h exp 0000010", wlog_addr[w0]); end
        n_checks++; if (wlog_data[w0] !== 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D) begin n_fail++; $display("FAIL single_data got %h", wlog_data[w0]); end
        n_checks++; if (wb_count !== 3'd0) begin n_fail++; $display("FAIL single_count0 got %0d exp 0", wb_count); end
        settle();
    endtask

    task automatic test_back_to_back;
        int w0, stall;
        w0 = wcnt; lat = 5;
        for (int a = 1; a <= 4; a++) begin
            c_write = 1'b1; c_address = 28'(a); c_writedata = blk(28'(a));
            #1;
            n_checks++; if (c_busywait !== 1'b0) begin n_fail++; $display("FAIL b2b_accept%0d got %b exp 0", a, c_busywait); end
            step();
        end
        c_address = 28'h5; c_writedata = blk(28'h5);
        #1;
        stall = 0;
        while (c_busywait && stall < 20) begin stall++; step(); end
        n_checks++; if (stall !== 3) begin n_fail++; $display("FAIL b2b_stall got %0d cycles exp 3", stall); end
        n_checks++; if (wcnt !== w0 + 1) begin n_fail++; $display("FAIL b2b_first_drain got %0d writes exp 1", wcnt - w0); end
        step();
        c_write = 1'b0;
        for (int k = 0; k < 100 && wcnt != w0 + 5; k++) step();
        n_checks++; if (wcnt !== w0 + 5) begin n_fail++; $display("FAIL b2b_total got %0d writes exp 5", wcnt - w0); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (wlog_addr[w0 + i] !== 28'(i + 1) || wlog_data[w0 + i] !== blk(28'(i + 1))) begin
                n_fail++; $display("FAIL b2b_order%0d got addr %h exp %h", i, wlog_addr[w0 + i], i + 1);
            end
        end
        settle();
    endtask

    task automatic test_forward;
        int w0, r0;
        logic [127:0] da, db;
        w0 = wcnt; r0 = rdcnt; lat = 5;
        da = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
        db = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
        c_write = 1'b1; c_address = 28'h20; c_writedata = da; step();
        c_writedata = db; step();
        c_write = 1'b0; c_read = 1'b1;
        #1;
        n_checks++; if (c_readdata !== db) begin n_fail++; $display("FAIL fwd_data got %h exp %h", c_readdata, db); end
        n_checks++; if (c_busywait !== 1'b0) begin n_fail++; $display("FAIL fwd_busy got %b exp 0", c_busywait); end
        n_checks++; if (mem_read !== 1'b0) begin n_fail++; $display("FAIL fwd_memread got %b exp 0", mem_read); end
        step();
        c_read = 1'b0;
        for (int k = 0; k < 60 && wcnt != w0 + 2; k++) step();
        n_checks++; if (wcnt !== w0 + 2 || wlog_data[w0] !== da || wlog_data[w0 + 1] !== db) begin
            n_fail++; $display("FAIL fwd_drain got %0d writes, first %h exp 2 writes A then B", wcnt - w0, wlog_data[w0]);
        end
        n_checks++; if (rdcnt !== r0) begin n_fail++; $display("FAIL fwd_no_read got %0d reads exp 0", rdcnt - r0); end
        settle();
    endtask

    task automatic test_read_miss;
        int n, r0;
        r0 = rdcnt; lat = 5;
        mem_readdata = 128'h3030_3030_1111_2222_3333_4444_5555_6666;
        c_read = 1'b1; c_address = 28'h30;
        #1;
        n = 0;
        while (c_busywait && n < 30) begin n++; step(); end
        n_checks++; if (n !== 6) begin n_fail++; $display("FAIL miss_busy got %0d cycles exp 6", n); end
        n_checks++; if (c_readdata !== 128'h3030_3030_1111_2222_3333_4444_5555_6666) begin n_fail++; $display("FAIL miss_data got %h", c_readdata); end
        n_checks++; if (rdcnt !== r0 + 1) begin n_fail++; $display("FAIL miss_reads got %0d exp 1", rdcnt - r0); end
        step();
        c_read = 1'b0;
        #1;
        n_checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL miss_idle_gap got rd=%b wr=%b exp 0 0", mem_read, mem_write); end
        settle();
    endtask

    task automatic test_read_during_drain;
        int w0;
        w0 = wcnt; lat = 5;
        for (int a = 0; a < 3; a++) begin
            c_write = 1'b1; c_address = 28'h50 + 28'(a); c_writedata = blk(28'h50 + 28'(a));
            step();
        end
        c_write = 1'b0; c_read = 1'b1; c_address = 28'h40; mem_readdata = blk(28'h40);
        #1;
        for (int k = 0; k < 30 && !mem_read; k++) step();
        n_checks++; if (mem_read !== 1'b1 || mem_address !== 28'h40) begin n_fail++; $display("FAIL rdd_issue got rd=%b addr=%h exp 1 040", mem_read, mem_address); end
        n_checks++; if (wcnt !== w0 + 1) begin n_fail++; $display("FAIL rdd_ahead got %0d drains exp 1", wcnt - w0); end
        for (int k = 0; k < 30 && c_busywait; k++) step();
        n_checks++; if (c_busywait !== 1'b0 || c_readdata !== blk(28'h40)) begin n_fail++; $display("FAIL rdd_data got busy=%b data=%h", c_busywait, c_readdata); end
        n_checks++; if (wb_count !== 3'd2) begin n_fail++; $display("FAIL rdd_pending got %0d exp 2", wb_count); end
        step();
        c_read = 1'b0;
        for (int k = 0; k < 60 && wcnt != w0 + 3; k++) step();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (wcnt !== w0 + 3 || wlog_addr[w0 + i] !== 28'h50 + 28'(i)) begin
                n_fail++; $display("FAIL rdd_order%0d got %h exp %h", i, wlog_addr[w0 + i], 28'h50 + 28'(i));
            end
        end
        settle();
    endtask

    task automatic test_reset_mid_drain;
        int w0;
        w0 = wcnt; lat = 5;
        c_write = 1'b1; c_address = 28'h10; c_writedata = blk(28'h10); step();
        c_address = 28'h61; c_writedata = blk(28'h61); step();
        c_address = 28'h62; c_writedata = blk(28'h62); step();
        c_write = 1'b0;
        for (int k = 0; k < 10 && !mem_write; k++) step();
        n_checks++; if (mem_write !== 1'b1 || wb_count !== 3'd3) begin n_fail++; $display("FAIL rst_pre got wr=%b count=%0d exp 1 3", mem_write, wb_count); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_memwrite got %b exp 0", mem_write); end
        n_checks++; if (wb_count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", wb_count); end
        #1 reset = 1'b0;
        step();
        c_read = 1'b1; c_address = 28'h10; mem_readdata = ~blk(28'h10);
        #1;
        n_checks++; if (c_busywait !== 1'b1) begin n_fail++; $display("FAIL rst_read_busy got %b exp 1", c_busywait); end
        for (int k = 0; k < 10 && !mem_read; k++) step();
        n_checks++; if (mem_read !== 1'b1 || mem_address !== 28'h10) begin n_fail++; $display("FAIL rst_read_issue got rd=%b addr=%h exp 1 010", mem_read, mem_address); end
        for (int k = 0; k < 30 && c_busywait; k++) step();
        n_checks++; if (c_readdata !== ~blk(28'h10)) begin n_fail++; $display("FAIL rst_read_data got %h exp %h", c_readdata, ~blk(28'h10)); end
        step();
        c_read = 1'b0;
        for (int k = 0; k < 10; k++) step();
        n_checks++; if (wcnt !== w0) begin n_fail++; $display("FAIL rst_discard got %0d writes exp 0", wcnt - w0); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_forward();
        test_read_miss();
        test_read_during_drain();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
